// File: rtl/approx_acc_pkg.sv
// Shared types and default sizing for the approximate-product accumulator.
// The optional ACC_SATURATE_EN build macro is consumed by approx_acc_adder.
package approx_acc_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } acc_state_e;

    localparam int DEF_PROD_W  = 16;
    localparam int DEF_ACC_W   = 24;
    localparam int DEF_MAX_LEN = 256;

    // Width needed to hold a term count from 0 up to and including max_len.
    function automatic int calc_cnt_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/approx_prod_accumulator_if.sv
// Product-stream input and per-packet result output of the accumulator.
// master drives products and consumes results; slave is the accumulator.
interface approx_prod_accumulator_if
    import approx_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = calc_cnt_w(DEF_MAX_LEN)
);

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_prod;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_sum;
    logic [CNT_W-1:0]  out_count;
    logic              out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );

endinterface

// File: rtl/approx_acc_adder.sv
// Combinational accumulate step: acc + zero-extended product, with carry.
// Build macro ACC_SATURATE_EN selects clamp-to-all-ones instead of wrap.
module approx_acc_adder
    import approx_acc_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [ACC_W:0]   prod_ext,
    output logic [ACC_W-1:0] acc_nxt,
    output logic             carry
);

`ifdef ACC_SATURATE_EN
    // Clamp on carry-out; an already all-ones acc stays all-ones.
    function automatic logic [ACC_W-1:0] limit_sum(input logic [ACC_W:0] raw);
        return raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
    endfunction
`else
    // Drop the carry bit so the sum wraps modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] limit_sum(input logic [ACC_W:0] raw);
        return raw[ACC_W-1:0];
    endfunction
`endif

    logic [ACC_W:0] raw_sum;

    // Full-width add keeps the carry-out visible for the overflow flag.
    always_comb begin
        raw_sum = {1'b0, acc} + prod_ext;
        carry   = raw_sum[ACC_W];
        acc_nxt = limit_sum(raw_sum);
    end

endmodule

// File: rtl/approx_prod_accumulator.sv
// Accumulates a valid/ready stream of unsigned products into one registered
// sum per packet (closed by in_last or by reaching MAX_LEN terms), with a
// term count and a sticky overflow flag. Build macro ACC_SATURATE_EN
// (handled in approx_acc_adder) switches wrap to saturating arithmetic.
module approx_prod_accumulator
    import approx_acc_pkg::*;
#(
    parameter int PROD_W  = DEF_PROD_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = calc_cnt_w(MAX_LEN)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    approx_prod_accumulator_if.slave  bus
);

    acc_state_e       state, state_nxt;
    logic [ACC_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ovf, ovf_nxt;

    logic [ACC_W-1:0] out_sum_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_ovf_q;
    logic             out_valid_q;

    logic             in_fire;
    logic             out_fire;
    logic             close_pkt;
    logic             load_out;
    logic [ACC_W-1:0] acc_base;
    logic [CNT_W-1:0] cnt_base;
    logic             ovf_base;
    logic [CNT_W-1:0] cnt_inc;
    logic [ACC_W:0]   prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;

    // A new beat may enter whenever the result slot is empty or draining now.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign in_fire       = bus.in_valid && bus.in_ready;
    assign out_fire      = out_valid_q && bus.out_ready;

    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_ovf   = out_ovf_q;

    // IDLE starts from zero so the first beat of a packet seeds the sum.
    assign acc_base  = (state == IDLE) ? '0 : acc;
    assign cnt_base  = (state == IDLE) ? '0 : cnt;
    assign ovf_base  = (state == IDLE) ? 1'b0 : ovf;
    assign cnt_inc   = cnt_base + CNT_W'(1);
    assign prod_ext  = {{(ACC_W + 1 - PROD_W){1'b0}}, bus.in_prod};
    assign close_pkt = bus.in_last || (cnt_inc == CNT_W'(MAX_LEN));

    approx_acc_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .acc      (acc_base),
        .prod_ext (prod_ext),
        .acc_nxt  (add_sum),
        .carry    (add_carry)
    );

    // State and running packet accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    // Next state: open or extend a packet on each beat, clear on close.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        load_out  = 1'b0;
        if (in_fire) begin
            if (close_pkt) begin
                state_nxt = IDLE;
                acc_nxt   = '0;
                cnt_nxt   = '0;
                ovf_nxt   = 1'b0;
                load_out  = 1'b1;
            end else begin
                state_nxt = ACC;
                acc_nxt   = add_sum;
                cnt_nxt   = cnt_inc;
                ovf_nxt   = ovf_base | add_carry;
            end
        end
    end

    // Result slot: a closing beat loads it (even while the old result drains),
    // otherwise it holds until consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else if (load_out) begin
            out_valid_q <= 1'b1;
            out_sum_q   <= add_sum;
            out_count_q <= cnt_inc;
            out_ovf_q   <= ovf_base | add_carry;
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_approx_prod_accumulator.sv
// Directed bench for approx_prod_accumulator, built with ACC_W=17 and
// MAX_LEN=4 so carry-out and forced packet close are reachable quickly.
// Expected overflow sum follows the ACC_SATURATE_EN build macro.
module tb_approx_prod_accumulator;

    localparam int PROD_W  = 16;
    localparam int ACC_W   = 17;
    localparam int MAX_LEN = 4;
    localparam int CNT_W   = 3;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    approx_prod_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    approx_prod_accumulator #(
        .PROD_W  (PROD_W),
        .ACC_W   (ACC_W),
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat, let it be clocked in, then sample 1 ns after the edge.
    task automatic beat(input logic [PROD_W-1:0] prod, input logic last);
        bus.in_valid = 1'b1;
        bus.in_prod  = prod;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_prod  = '0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        vectors++; if (bus.out_sum !== 17'd0) begin miscompares++; $display("FAIL reset_out_sum got %0d want 0", bus.out_sum); end
        vectors++; if (bus.out_count !== 3'd0) begin miscompares++; $display("FAIL reset_out_count got %0d want 0", bus.out_count); end
        vectors++; if (bus.out_ovf !== 1'b0) begin miscompares++; $display("FAIL reset_out_ovf got %0b want 0", bus.out_ovf); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); end
    endtask

    task automatic test_basic_packet();
        bus.out_ready = 1'b1;
        beat(16'd3, 1'b0);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_early_valid got %0b want 0", bus.out_valid); end
        beat(16'd5, 1'b0);
        beat(16'd7, 1'b1);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %0b want 1", bus.out_valid); end
        vectors++; if (bus.out_sum !== 17'd15) begin miscompares++; $display("FAIL basic_sum got %0d want 15", bus.out_sum); end
        vectors++; if (bus.out_count !== 3'd3) begin miscompares++; $display("FAIL basic_count got %0d want 3", bus.out_count); end
        vectors++; if (bus.out_ovf !== 1'b0) begin miscompares++; $display("FAIL basic_ovf got %0b want 0", bus.out_ovf); end
        @(posedge clk); #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_valid_drop got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_single_beat();
        beat(16'd65025, 1'b1);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %0b want 1", bus.out_valid); end
        vectors++; if (bus.out_sum !== 17'd65025) begin miscompares++; $display("FAIL single_sum got %0d want 65025", bus.out_sum); end
        vectors++; if (bus.out_count !== 3'd1) begin miscompares++; $display("FAIL single_count got %0d want 1", bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        beat(16'd4, 1'b0);
        beat(16'd6, 1'b1);
        vectors++; if (bus.out_sum !== 17'd10) begin miscompares++; $display("FAIL bp_sum got %0d want 10", bus.out_sum); end
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_prod  = 16'd99;
            bus.in_last  = 1'b1;
            #1;
            vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready[%0d] got %0b want 0", i, bus.in_ready); end
            @(posedge clk); #1;
            vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid[%0d] got %0b want 1", i, bus.out_valid); end
            vectors++; if (bus.out_sum !== 17'd10) begin miscompares++; $display("FAIL bp_hold_sum[%0d] got %0d want 10", i, bus.out_sum); end
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %0b want 1", bus.in_ready); end
        @(posedge clk); #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_consumed got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        logic [ACC_W-1:0] exp_sum;
`ifdef ACC_SATURATE_EN
        exp_sum = 17'd131071;
`else
        exp_sum = 17'd0;
`endif
        beat(16'd65535, 1'b0);
        beat(16'd65535, 1'b0);
        beat(16'd2, 1'b1);
        vectors++; if (bus.out_sum !== exp_sum) begin miscompares++; $display("FAIL ovf_sum got %0d want %0d", bus.out_sum, exp_sum); end
        vectors++; if (bus.out_ovf !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %0b want 1", bus.out_ovf); end
        vectors++; if (bus.out_count !== 3'd3) begin miscompares++; $display("FAIL ovf_count got %0d want 3", bus.out_count); end
        beat(16'd1, 1'b1);
        vectors++; if (bus.out_ovf !== 1'b0) begin miscompares++; $display("FAIL ovf_cleared got %0b want 0", bus.out_ovf); end
        vectors++; if (bus.out_sum !== 17'd1) begin miscompares++; $display("FAIL ovf_next_sum got %0d want 1", bus.out_sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_max_len();
        for (int i = 0; i < 4; i++) beat(16'd1, 1'b0);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL maxlen_valid got %0b want 1", bus.out_valid); end
        vectors++; if (bus.out_sum !== 17'd4) begin miscompares++; $display("FAIL maxlen_sum got %0d want 4", bus.out_sum); end
        vectors++; if (bus.out_count !== 3'd4) begin miscompares++; $display("FAIL maxlen_count got %0d want 4", bus.out_count); end
        beat(16'd1, 1'b0);
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL maxlen_gap_valid got %0b want 0", bus.out_valid); end
        beat(16'd1, 1'b1);
        vectors++; if (bus.out_sum !== 17'd2) begin miscompares++; $display("FAIL maxlen_tail_sum got %0d want 2", bus.out_sum); end
        vectors++; if (bus.out_count !== 3'd2) begin miscompares++; $display("FAIL maxlen_tail_count got %0d want 2", bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_idle_gap();
        beat(16'd2, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL gap_valid got %0b want 0", bus.out_valid); end
        end
        beat(16'd3, 1'b1);
        vectors++; if (bus.out_sum !== 17'd5) begin miscompares++; $display("FAIL gap_sum got %0d want 5", bus.out_sum); end
        vectors++; if (bus.out_count !== 3'd2) begin miscompares++; $display("FAIL gap_count got %0d want 2", bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        beat(16'd9, 1'b1);
        vectors++; if (bus.out_sum !== 17'd9) begin miscompares++; $display("FAIL b2b_first got %0d want 9", bus.out_sum); end
        beat(16'd11, 1'b1);
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid got %0b want 1", bus.out_valid); end
        vectors++; if (bus.out_sum !== 17'd11) begin miscompares++; $display("FAIL b2b_second got %0d want 11", bus.out_sum); end
        @(posedge clk); #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drop got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        beat(16'd8, 1'b1);
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_pending_valid got %0b want 0", bus.out_valid); end
        vectors++; if (bus.out_sum !== 17'd0) begin miscompares++; $display("FAIL rst_pending_sum got %0d want 0", bus.out_sum); end
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        beat(16'd5, 1'b0);
        beat(16'd6, 1'b0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid got %0b want 0", bus.out_valid); end
        beat(16'd1, 1'b1);
        vectors++; if (bus.out_sum !== 17'd1) begin miscompares++; $display("FAIL rst_after_sum got %0d want 1", bus.out_sum); end
        vectors++; if (bus.out_count !== 3'd1) begin miscompares++; $display("FAIL rst_after_count got %0d want 1", bus.out_count); end
        @(posedge clk); #1;
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_basic_packet();
        test_single_beat();
        test_backpressure();
        test_overflow();
        test_max_len();
        test_idle_gap();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
